// File: rtl/branch_cmp_if.sv
// Bus between the ID-stage operand/opcode source and the branch comparator.
// It carries the forwarded operands, the branch opcode and the stall enable
// into the comparator. It carries the combinational taken flag and the
// registered flags back out.
interface branch_cmp_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] RF_RD1;
    logic [WIDTH-1:0] RF_RD2;
    logic [2:0]       branchop;
    logic             cmp_out;
    logic             cmp_out_q;
    logic             eq_q;
    logic             lts_q;
    logic             ltu_q;

    // ID-stage side: drives operands and opcode, consumes the decision.
    modport master (
        output en,
        output RF_RD1,
        output RF_RD2,
        output branchop,
        input  cmp_out,
        input  cmp_out_q,
        input  eq_q,
        input  lts_q,
        input  ltu_q
    );

    // Comparator side.
    modport slave (
        input  en,
        input  RF_RD1,
        input  RF_RD2,
        input  branchop,
        output cmp_out,
        output cmp_out_q,
        output eq_q,
        output lts_q,
        output ltu_q
    );
endinterface

// File: rtl/branch_cmp.sv
// Branch-condition comparator for the ID stage.
// cmp_out is a pure combinational function of the operands and the opcode,
// and it feeds next-PC selection in the same cycle. The registered copy and
// the raw relational flags are for the ID/EX register. These registers clear
// on a synchronous reset and hold while the pipeline stalls (en=0).
module branch_cmp #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    branch_cmp_if.slave bus
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;

    logic w_eq;
    logic w_lts;
    logic w_ltu;
    logic w_neg;
    logic w_zero;
    logic w_taken;

    logic r_cmp_out_q;
    logic r_eq_q;
    logic r_lts_q;
    logic r_ltu_q;

    // The zero and sign tests look only at RF_RD1.
    assign w_eq   = (bus.RF_RD1 == bus.RF_RD2);
    assign w_lts  = ($signed(bus.RF_RD1) < $signed(bus.RF_RD2));
    assign w_ltu  = (bus.RF_RD1 < bus.RF_RD2);
    assign w_neg  = bus.RF_RD1[WIDTH-1];
    assign w_zero = (bus.RF_RD1 == '0);

    // Decode the branch condition. Opcodes 6 and 7 are reserved and never taken.
    always_comb begin
        w_taken = 1'b0;
        case (bus.branchop)
            OP_BEQ:  w_taken = w_eq;
            OP_BNE:  w_taken = !w_eq;
            OP_BLEZ: w_taken = w_neg || w_zero;
            OP_BGTZ: w_taken = !w_neg && !w_zero;
            OP_BLTZ: w_taken = w_neg;
            OP_BGEZ: w_taken = !w_neg;
            default: w_taken = 1'b0;
        endcase
    end

    // ID/EX copies: reset wins over enable, and a stall holds the registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp_out_q <= 1'b0;
            r_eq_q      <= 1'b0;
            r_lts_q     <= 1'b0;
            r_ltu_q     <= 1'b0;
        end else if (bus.en) begin
            r_cmp_out_q <= w_taken;
            r_eq_q      <= w_eq;
            r_lts_q     <= w_lts;
            r_ltu_q     <= w_ltu;
        end
    end

    assign bus.cmp_out   = w_taken;
    assign bus.cmp_out_q = r_cmp_out_q;
    assign bus.eq_q      = r_eq_q;
    assign bus.lts_q     = r_lts_q;
    assign bus.ltu_q     = r_ltu_q;

endmodule

// File: tb/tb_branch_cmp.sv
// Scoreboard bench for branch_cmp. The driver issues one operand set per
// cycle. It queues the expected combinational decision for that cycle and
// the expected registered flags for the following cycle. A monitor compares
// both on the falling edge.
module tb_branch_cmp;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    branch_cmp_if #(.WIDTH(32)) bus ();

    branch_cmp #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic taken;
    } comb_exp_t;

    typedef struct {
        int   due;
        logic cq;
        logic eq;
        logic lts;
        logic ltu;
    } reg_exp_t;

    comb_exp_t q_comb[$];
    reg_exp_t  q_reg[$];

    // Reference state of the registered outputs (X until the first reset).
    logic m_cq, m_eq, m_lts, m_ltu;

    function automatic longint sval(input logic [31:0] v);
        longint t;
        t = longint'({32'b0, v});
        if (t >= 64'sd2147483648) t = t - 64'sd4294967296;
        return t;
    endfunction

    function automatic longint uval(input logic [31:0] v);
        return longint'({32'b0, v});
    endfunction

    function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
        case (op)
            3'd0:    return uval(a) == uval(b);
            3'd1:    return uval(a) != uval(b);
            3'd2:    return sval(a) <= 0;
            3'd3:    return sval(a) > 0;
            3'd4:    return sval(a) < 0;
            3'd5:    return sval(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic en, input logic rst);
        comb_exp_t ce;
        reg_exp_t  re;
        @(posedge clk);
        #1;
        bus.RF_RD1   = a;
        bus.RF_RD2   = b;
        bus.branchop = op;
        bus.en       = en;
        reset        = rst;
        ce.due   = cyc;
        ce.taken = ref_taken(a, b, op);
        q_comb.push_back(ce);
        if (rst) begin
            m_cq = 1'b0; m_eq = 1'b0; m_lts = 1'b0; m_ltu = 1'b0;
        end else if (en) begin
            m_cq  = ce.taken;
            m_eq  = (uval(a) == uval(b));
            m_lts = (sval(a) < sval(b));
            m_ltu = (uval(a) < uval(b));
        end
        re.due = cyc + 1;
        re.cq  = m_cq;
        re.eq  = m_eq;
        re.lts = m_lts;
        re.ltu = m_ltu;
        q_reg.push_back(re);
    endtask

    // Monitor: compares every expectation that falls due in this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q_comb.size() > 0 && q_comb[0].due == cyc) begin
                comb_exp_t ce;
                ce = q_comb.pop_front();
                check("cmp_out", bus.cmp_out, ce.taken);
            end
            while (q_reg.size() > 0 && q_reg[0].due == cyc) begin
                reg_exp_t re;
                re = q_reg.pop_front();
                check("cmp_out_q", bus.cmp_out_q, re.cq);
                check("eq_q", bus.eq_q, re.eq);
                check("lts_q", bus.lts_q, re.lts);
                check("ltu_q", bus.ltu_q, re.ltu);
            end
        end
    end

    task automatic rand_operands(output logic [31:0] a, output logic [31:0] b);
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 6))
            0: b = a;
            1: a = 32'h0;
            2: begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
            3: b = a + 32'd1;
            4: b = a - 32'd1;
            5: a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_0001;
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] a, b;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.RF_RD1 = '0;
        bus.RF_RD2 = '0;
        bus.branchop = 3'd0;

        issue(32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
        issue(32'h0, 32'h0, 3'd0, 1'b1, 1'b1);

        // Sign boundary with RF_RD1 = -1.
        for (int op = 2; op <= 5; op++) issue(32'hFFFF_FFFF, 32'h0, op[2:0], 1'b1, 1'b0);
        // Equal operands.
        issue(32'h1234_5678, 32'h1234_5678, 3'd1, 1'b1, 1'b0);
        issue(32'h1234_5678, 32'h1234_5678, 3'd0, 1'b1, 1'b0);
        // Zero boundary.
        issue(32'h0, $urandom, 3'd2, 1'b1, 1'b0);
        issue(32'h0, $urandom, 3'd3, 1'b1, 1'b0);
        issue(32'h0, $urandom, 3'd5, 1'b1, 1'b0);
        // Signed and unsigned compare disagree.
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd4, 1'b1, 1'b0);
        // Reserved opcodes.
        issue(32'h5, 32'h5, 3'd6, 1'b1, 1'b0);
        issue(32'h0, 32'h0, 3'd7, 1'b1, 1'b0);
        // Load a taken result, stall for 3 cycles while inputs change, then reset.
        issue(32'h1234_5678, 32'h1234_5678, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) issue($urandom, $urandom, 3'd1 + i[2:0], 1'b0, 1'b0);
        issue(32'h7, 32'h7, 3'd0, 1'b1, 1'b1);
        issue(32'h7, 32'h7, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rand_operands(a, b);
            issue(a, b, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q_comb.size() != 0 || q_reg.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d comb and %0d reg expectations left, expected 0",
                     q_comb.size(), q_reg.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
